stop_watch_ctrl: RTL and testbench

Control sequencer for the three-digit BCD cascade stopwatch counter: XX.X seconds, digits d2 d1 d0.
- Turns two debounced push-button levels into the counter's `go` and `clr` controls.
- Provides a lap (split) hold that freezes the displayed digits while counting continues.
- Auto-stops the counter at 99.9 s.
- Sits between the debouncers and the counter; its `q*` outputs feed the seven-segment display multiplexer.

---
 rtl/stop_watch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_stop_watch_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stop_watch_ctrl.sv
// Stopwatch control sequencer: buttons to go/clr, lap hold, auto-stop at 99.9 s.
// Define STOP_WATCH_LAP_EN to build the LAP state, snapshot registers and display mux.
module stop_watch_ctrl #(
  parameter bit AUTO_STOP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  output logic       go,
  output logic       clr,
  output logic [3:0] q2,
  output logic [3:0] q1,
  output logic [3:0] q0,
  output logic       running,
  output logic       lap_hold,
  output logic       ovf
);

  localparam int unsigned DW = 4;
  localparam int unsigned VW = 3 * DW;
  localparam logic [VW-1:0] MAX_VAL = VW'(12'h999);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          ss_prev_q, lr_prev_q;
  logic          ss_press_q, lr_press_q;
  logic          go_q, go_d;
  logic          clr_q, clr_d;
  logic          ovf_q, ovf_d;
  logic [VW-1:0] q_q, q_d;
  logic [VW-1:0] live_c;
  logic          hit_c;
  logic          ss_c, lr_c;

  assign live_c = {d2, d1, d0};
  assign hit_c  = AUTO_STOP && (live_c == MAX_VAL) &&
                  ((state_q == S_RUN) || (state_q == S_LAP));
  // A simultaneous start/stop press masks the lap/reset press.
  assign ss_c   = ss_press_q;
  assign lr_c   = lr_press_q & ~ss_press_q;

`ifdef STOP_WATCH_LAP_EN
  logic          lap_q, lap_d;
  logic [VW-1:0] snap_q, snap_d;
`endif

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    clr_d   = 1'b0;
`ifdef STOP_WATCH_LAP_EN
    snap_d  = snap_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ss_c) begin
          state_d = S_RUN;
        end else if (lr_c) begin
          clr_d = 1'b1;
        end
      end
      S_RUN: begin
        if (hit_c) begin
          state_d = S_PAUSE;
          ovf_d   = 1'b1;
        end else if (ss_c) begin
          state_d = S_PAUSE;
`ifdef STOP_WATCH_LAP_EN
        end else if (lr_c) begin
          state_d = S_LAP;
          snap_d  = live_c;
`endif
        end
      end
`ifdef STOP_WATCH_LAP_EN
      S_LAP: begin
        if (hit_c) begin
          state_d = S_PAUSE;
          ovf_d   = 1'b1;
        end else if (ss_c) begin
          state_d = S_PAUSE;
        end else if (lr_c) begin
          state_d = S_RUN;
        end
      end
`endif
      S_PAUSE: begin
        if (ss_c) begin
          if (!ovf_q) state_d = S_RUN;
        end else if (lr_c) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    go_d = (state_d == S_RUN) || (state_d == S_LAP);
`ifdef STOP_WATCH_LAP_EN
    lap_d = (state_d == S_LAP);
    q_d   = lap_d ? snap_d : live_c;
`else
    q_d   = live_c;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ss_prev_q  <= 1'b1;
      lr_prev_q  <= 1'b1;
      ss_press_q <= 1'b0;
      lr_press_q <= 1'b0;
      state_q    <= S_IDLE;
      go_q       <= 1'b0;
      clr_q      <= 1'b1;
      ovf_q      <= 1'b0;
      q_q        <= '0;
    end else begin
      ss_prev_q  <= btn_ss;
      lr_prev_q  <= btn_lr;
      ss_press_q <= btn_ss & ~ss_prev_q;
      lr_press_q <= btn_lr & ~lr_prev_q;
      state_q    <= state_d;
      go_q       <= go_d;
      clr_q      <= clr_d;
      ovf_q      <= ovf_d;
      q_q        <= q_d;
    end
  end

`ifdef STOP_WATCH_LAP_EN
  // Lap snapshot and display-hold flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q  <= 1'b0;
      snap_q <= '0;
    end else begin
      lap_q  <= lap_d;
      snap_q <= snap_d;
    end
  end

  assign lap_hold = lap_q;
`else
  assign lap_hold = 1'b0;
`endif

  assign go      = go_q;
  assign running = go_q;
  assign clr     = clr_q;
  assign ovf     = ovf_q;
  assign q2      = q_q[3*DW-1:2*DW];
  assign q1      = q_q[2*DW-1:DW];
  assign q0      = q_q[DW-1:0];

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Bench for stop_watch_ctrl: directed scenarios plus randomized buttons/digits
// checked every cycle against a flag-based behavioural model.
module tb_stop_watch_ctrl;

  logic        clk = 1'b0;
  logic        reset, btn_ss, btn_lr;
  logic [11:0] dv;
  logic [3:0]  d2, d1, d0, q2, q1, q0;
  logic        go, clr, running, lap_hold, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  assign d2 = dv[11:8];
  assign d1 = dv[7:4];
  assign d0 = dv[3:0];

  always #5 clk = ~clk;

  stop_watch_ctrl #(.AUTO_STOP(1'b1)) dut (
    .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .d2(d2), .d1(d1), .d0(d0),
    .go(go), .clr(clr), .q2(q2), .q1(q1), .q0(q0),
    .running(running), .lap_hold(lap_hold), .ovf(ovf)
  );

`ifdef STOP_WATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  // Model: counting/lap/ovf flags; idle and paused differ only by ovf, which idle never holds.
  logic        m_valid = 1'b0;
  logic        m_prev_ss, m_prev_lr, m_pss, m_plr;
  logic        m_go, m_lap, m_ovf, m_clr;
  logic [11:0] m_snap, m_q;

  task automatic model_step();
    logic ss, lr, hit;
    if (reset) begin
      m_prev_ss = 1'b1; m_prev_lr = 1'b1; m_pss = 1'b0; m_plr = 1'b0;
      m_go = 1'b0; m_lap = 1'b0; m_ovf = 1'b0; m_clr = 1'b1;
      m_snap = 12'h000; m_q = 12'h000;
    end else begin
      hit = (dv == 12'h999) && m_go;
      ss  = m_pss;
      lr  = m_plr && !m_pss;
      m_clr = 1'b0;
      if (hit) begin
        m_go = 1'b0; m_lap = 1'b0; m_ovf = 1'b1;
      end else if (ss) begin
        if (m_go) begin
          m_go = 1'b0; m_lap = 1'b0;
        end else if (!m_ovf) begin
          m_go = 1'b1;
        end
      end else if (lr) begin
        if (!m_go) begin
          m_clr = 1'b1; m_ovf = 1'b0;
        end else if (m_lap) begin
          m_lap = 1'b0;
        end else if (LAP_EN) begin
          m_lap = 1'b1; m_snap = dv;
        end
      end
      m_q   = m_lap ? m_snap : dv;
      m_pss = btn_ss && !m_prev_ss;
      m_plr = btn_lr && !m_prev_lr;
      m_prev_ss = btn_ss;
      m_prev_lr = btn_lr;
    end
    m_valid = 1'b1;
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int k = 0; k < 3; k++) begin
      if (r[k*4 +: 4] >= 4'd9) begin
        r[k*4 +: 4] = 4'd0;
      end else begin
        r[k*4 +: 4] = r[k*4 +: 4] + 4'd1;
        return r;
      end
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("go",       12'(go),             12'(m_go));
        chk("running",  12'(running),        12'(m_go));
        chk("clr",      12'(clr),            12'(m_clr));
        chk("ovf",      12'(ovf),            12'(m_ovf));
        chk("lap_hold", 12'(lap_hold),       12'(m_lap));
        chk("q",        {q2, q1, q0},        m_q);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] r;
    reset = 1'b1; btn_ss = 1'b1; btn_lr = 1'b0; dv = 12'h000;

    // Reset with start/stop held through it.
    tick(); tick(); tick();
    chk("rst_clr", 12'(clr), 12'h1);
    chk("rst_go",  12'(go),  12'h0);
    chk("rst_q",   {q2, q1, q0}, 12'h000);
    reset = 1'b0;
    tick();
    chk("rel_clr", 12'(clr), 12'h0);
    tick(); tick();
    chk("held_go", 12'(go), 12'h0);

    // Start: go two cycles after the press.
    btn_ss = 1'b0; tick();
    btn_ss = 1'b1; tick();
    chk("start_lat1", 12'(go), 12'h0);
    tick();
    chk("start_go", 12'(go), 12'h1);

    // Stop to PAUSE, then lr to IDLE with one clr cycle.
    btn_ss = 1'b0; tick();
    btn_ss = 1'b1; tick(); tick();
    chk("pause_go", 12'(go), 12'h0);
    btn_ss = 1'b0; btn_lr = 1'b1; tick();
    chk("clr_pre", 12'(clr), 12'h0);
    tick();
    chk("clr_pulse", 12'(clr), 12'h1);
    tick();
    chk("clr_post", 12'(clr), 12'h0);
    btn_lr = 1'b0;

    // Run, then lap at 1,2,3 while the live value moves on.
    btn_ss = 1'b1; tick(); tick();
    chk("run_go", 12'(go), 12'h1);
    btn_ss = 1'b0;
    dv = 12'h123; btn_lr = 1'b1; tick(); tick();
    chk("lap_q_load", {q2, q1, q0}, 12'h123);
`ifdef STOP_WATCH_LAP_EN
    chk("lap_hold_on", 12'(lap_hold), 12'h1);
    dv = 12'h150; tick();
    chk("lap_q_frozen", {q2, q1, q0}, 12'h123);
`else
    chk("nolap_hold", 12'(lap_hold), 12'h0);
    dv = 12'h150; tick();
    chk("nolap_q_live", {q2, q1, q0}, 12'h150);
`endif
    btn_lr = 1'b0; tick();
    btn_lr = 1'b1; tick(); tick();
    chk("lap_release", 12'(lap_hold), 12'h0);
    chk("lap_rel_q",   {q2, q1, q0}, 12'h150);
    chk("lap_rel_go",  12'(go), 12'h1);
    btn_lr = 1'b0;

    // Auto-stop at 9,9,9; ss ignored while ovf; lr clears.
    dv = 12'h999; tick();
    chk("ovf_go",  12'(go),  12'h0);
    chk("ovf_set", 12'(ovf), 12'h1);
    btn_ss = 1'b1; tick(); tick(); tick();
    chk("ovf_ss_ignored", 12'(go), 12'h0);
    btn_ss = 1'b0; btn_lr = 1'b1; tick(); tick();
    chk("ovf_clr",   12'(clr), 12'h1);
    chk("ovf_clear", 12'(ovf), 12'h0);
    btn_lr = 1'b0; dv = 12'h000; tick();

    // Simultaneous presses in RUN: stop wins, no lap.
    btn_ss = 1'b1; tick(); tick();
    chk("both_run", 12'(go), 12'h1);
    btn_ss = 1'b0; tick();
    btn_ss = 1'b1; btn_lr = 1'b1; tick(); tick();
    chk("both_go",  12'(go),       12'h0);
    chk("both_lap", 12'(lap_hold), 12'h0);
    btn_ss = 1'b0; btn_lr = 1'b0; tick();

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      tick();
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) btn_ss = ~btn_ss;
      if ($urandom_range(0, 5) == 0) btn_lr = ~btn_lr;
      r = 6'($urandom_range(0, 39));
      if (r == 6'd0)      dv = 12'h999;
      else if (r == 6'd1) dv = 12'h998;
      else if (r == 6'd2) dv = 12'($urandom);
      else if (m_clr)     dv = 12'h000;
      else if (m_go)      dv = bcd_inc(dv);
    end
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
